// File: rtl/data_bus_sel.sv
// Registered video data-bus selector: routes one channel or the simulation stream downstream.
// Configuration changes take effect only at sweep start, followed by a blanking window.
module data_bus_sel #(
    parameter int W         = 4,
    parameter int NCH       = 3,
    parameter int SELW      = 2,
    parameter int MTI_CH    = 2,
    parameter int BLANK_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [SELW-1:0]   mode_ch,
    input  logic              mode_auto,
    input  logic              data_source,
    input  logic              auto,
    input  logic [NCH*W-1:0]  bits_in,
    input  logic [W-1:0]      simulate,
    input  logic              in_valid,
    output logic [W-1:0]      bits,
    output logic              bits_valid,
    output logic              mti_nv,
    output logic [SELW-1:0]   act_ch,
    output logic              blanking
);

    typedef enum logic {RUN, BLANK} state_e;

    localparam logic [7:0]      BLANK_LOAD = 8'(BLANK_CYC);
    localparam logic [SELW-1:0] MTI_SEL    = SELW'(MTI_CH);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [SELW-1:0]   act_ch_q, act_ch_d;
    logic              act_auto_q, act_auto_d;
    logic              act_src_q, act_src_d;
    logic [W-1:0]      bits_q, bits_d;
    logic              bits_valid_q, bits_valid_d;
    logic              mti_nv_q, mti_nv_d;

    logic [SELW-1:0]   req_ch;
    logic              cfg_change;
    logic [W-1:0]      sel_data;
    logic              sel_mti;

    // Out-of-range channel requests fall back to channel 0 before comparison.
    assign req_ch     = (int'(mode_ch) >= NCH) ? '0 : mode_ch;
    assign cfg_change = trig && ({req_ch, mode_auto, data_source} !=
                                 {act_ch_q, act_auto_q, act_src_q});

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_ch_d   = act_ch_q;
        act_auto_d = act_auto_q;
        act_src_d  = act_src_q;

        if (cfg_change) begin
            act_ch_d   = req_ch;
            act_auto_d = mode_auto;
            act_src_d  = data_source;
            if (BLANK_CYC != 0) begin
                state_d = BLANK;
                cnt_d   = BLANK_LOAD;
            end
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = RUN;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Selection uses the configuration active in the sampling cycle, not the one being loaded.
    always_comb begin
        sel_data = bits_in[act_ch_q*W +: W];
        if (act_src_q) begin
            sel_data = simulate;
        end else if (act_auto_q && auto) begin
            sel_data = bits_in[MTI_CH*W +: W];
        end
        sel_mti = act_auto_q ? auto : (act_ch_q == MTI_SEL);
    end

    always_comb begin
        bits_d       = bits_q;
        mti_nv_d     = mti_nv_q;
        bits_valid_d = in_valid;
        if (state_d == BLANK) begin
            bits_d       = '0;
            mti_nv_d     = 1'b0;
            bits_valid_d = 1'b0;
        end else if (in_valid) begin
            bits_d   = sel_data;
            mti_nv_d = sel_mti;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            cnt_q        <= 8'd0;
            act_ch_q     <= '0;
            act_auto_q   <= 1'b0;
            act_src_q    <= 1'b0;
            bits_q       <= '0;
            bits_valid_q <= 1'b0;
            mti_nv_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_ch_q     <= act_ch_d;
            act_auto_q   <= act_auto_d;
            act_src_q    <= act_src_d;
            bits_q       <= bits_d;
            bits_valid_q <= bits_valid_d;
            mti_nv_q     <= mti_nv_d;
        end
    end

    assign bits       = bits_q;
    assign bits_valid = bits_valid_q;
    assign mti_nv     = mti_nv_q;
    assign act_ch     = act_ch_q;
    assign blanking   = (state_q == BLANK);

endmodule

// File: tb/tb_data_bus_sel.sv
// Self-checking bench for data_bus_sel: directed scenarios then random traffic,
// compared against a cycle-numbered reference model of the selection and blanking rules.
module tb_data_bus_sel;

    localparam int W         = 4;
    localparam int NCH       = 3;
    localparam int SELW      = 2;
    localparam int MTI_CH    = 2;
    localparam int BLANK_CYC = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trig;
    logic [SELW-1:0]   mode_ch;
    logic              mode_auto;
    logic              data_source;
    logic              auto;
    logic [NCH*W-1:0]  bits_in;
    logic [W-1:0]      simulate;
    logic              in_valid;
    logic [W-1:0]      bits;
    logic              bits_valid;
    logic              mti_nv;
    logic [SELW-1:0]   act_ch;
    logic              blanking;

    logic [W-1:0]      ch [NCH];

    int tests    = 0;
    int failures = 0;

    // Reference model: active configuration plus the last cycle number that is blanked.
    int                cyc;
    int                blank_until;
    logic [SELW-1:0]   m_ch;
    logic              m_auto;
    logic              m_src;
    logic [W-1:0]      e_bits;
    logic              e_valid;
    logic              e_mti;
    logic              e_blank;

    always #5 clk = ~clk;

    always_comb begin
        bits_in = '0;
        for (int k = 0; k < NCH; k++) bits_in[k*W +: W] = ch[k];
    end

    data_bus_sel #(
        .W(W), .NCH(NCH), .SELW(SELW), .MTI_CH(MTI_CH), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .mode_ch(mode_ch),
        .mode_auto(mode_auto), .data_source(data_source), .auto(auto),
        .bits_in(bits_in), .simulate(simulate), .in_valid(in_valid),
        .bits(bits), .bits_valid(bits_valid), .mti_nv(mti_nv),
        .act_ch(act_ch), .blanking(blanking)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        check("bits",       32'(bits),       32'(e_bits));
        check("bits_valid", 32'(bits_valid), 32'(e_valid));
        check("mti_nv",     32'(mti_nv),     32'(e_mti));
        check("act_ch",     32'(act_ch),     32'(m_ch));
        check("blanking",   32'(blanking),   32'(e_blank));
    endtask

    task automatic model_reset();
        blank_until = -1;
        m_ch    = '0;
        m_auto  = 1'b0;
        m_src   = 1'b0;
        e_bits  = '0;
        e_valid = 1'b0;
        e_mti   = 1'b0;
        e_blank = 1'b0;
    endtask

    // One clock: the model consumes the inputs of cycle cyc and predicts the outputs of cycle cyc+1.
    task automatic tick();
        logic [SELW-1:0] o_ch;
        logic            o_auto;
        logic            o_src;
        logic [SELW-1:0] req;
        @(posedge clk);
        o_ch   = m_ch;
        o_auto = m_auto;
        o_src  = m_src;
        if (trig) begin
            req = (int'(mode_ch) >= NCH) ? '0 : mode_ch;
            if (req != m_ch || mode_auto != m_auto || data_source != m_src) begin
                m_ch   = req;
                m_auto = mode_auto;
                m_src  = data_source;
                if (BLANK_CYC > 0) blank_until = cyc + BLANK_CYC;
            end
        end
        e_blank = (cyc + 1 <= blank_until);
        if (e_blank) begin
            e_bits  = '0;
            e_valid = 1'b0;
            e_mti   = 1'b0;
        end else begin
            e_valid = in_valid;
            if (in_valid) begin
                if (o_src)                e_bits = simulate;
                else if (o_auto && auto)  e_bits = ch[MTI_CH];
                else                      e_bits = ch[o_ch];
                e_mti = o_auto ? auto : (int'(o_ch) == MTI_CH);
            end
        end
        cyc++;
        #1;
        check_all();
    endtask

    initial begin
        cyc = 0;
        model_reset();
        rst_n = 1'b0; trig = 1'b0; mode_ch = '0; mode_auto = 1'b0; data_source = 1'b0;
        auto = 1'b0; simulate = '0; in_valid = 1'b0;
        for (int k = 0; k < NCH; k++) ch[k] = '0;

        // Reset state.
        #12;
        check_all();
        rst_n = 1'b1;

        // Channel 0 passes straight through with one cycle of latency.
        ch[0] = 4'h3; ch[1] = 4'hA; ch[2] = 4'h5; in_valid = 1'b1;
        tick();
        check("first_bits", 32'(bits), 32'h3);

        // A pending mode_ch without trig is ignored.
        mode_ch = 2'd1;
        repeat (3) tick();
        check("no_trig_ch", 32'(act_ch), 32'd0);

        // Trig with a new channel: eight blanked cycles, then channel 1 data.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (BLANK_CYC - 1) tick();
        check("blank_last", 32'(blanking), 32'd1);
        tick();
        check("after_blank", 32'(bits), 32'hA);

        // Auto mode with channel 0 manual: auto toggles pick MTI per cell.
        ch[0] = 4'h1; mode_ch = 2'd0; mode_auto = 1'b1; trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (BLANK_CYC) tick();
        auto = 1'b1; tick();
        check("auto_mti", 32'(bits), 32'h5);
        auto = 1'b0; tick();
        check("auto_nv", 32'(bits), 32'h1);
        auto = 1'b1; tick();
        check("auto_mti2", 32'(mti_nv), 32'h1);

        // Simulation source, with a second differing trig three cycles into the blank.
        data_source = 1'b1; trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (2) tick();
        mode_ch = 2'd1; trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (BLANK_CYC - 1) tick();
        check("ext_blank", 32'(blanking), 32'd1);
        for (int i = 0; i < 16; i++) begin
            simulate = 4'(i);
            auto = 1'($urandom_range(0, 1));
            tick();
        end

        // Out-of-range channel clamps to 0; then an identical trig leaves data untouched.
        data_source = 1'b0; mode_auto = 1'b0; mode_ch = 2'd3; trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (BLANK_CYC) tick();
        trig = 1'b1;
        tick();
        check("same_cfg_noblank", 32'(blanking), 32'd0);
        trig = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a blank aborts it asynchronously.
        mode_ch = 2'd2; trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        tick();
        check("post_reset_blank", 32'(blanking), 32'd0);
        tick();

        // Random traffic: occasional (sometimes repeated) trigs and random request values.
        for (int i = 0; i < 400; i++) begin
            trig        = ($urandom_range(0, 11) == 0);
            mode_ch     = SELW'($urandom_range(0, 3));
            mode_auto   = 1'($urandom_range(0, 1));
            data_source = ($urandom_range(0, 3) == 0);
            auto        = 1'($urandom_range(0, 1));
            in_valid    = ($urandom_range(0, 4) != 0);
            simulate    = W'($urandom);
            for (int k = 0; k < NCH; k++) ch[k] = W'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_sel.md
# data_bus_sel

Parametrised, registered video data-bus selector for the radar signal path. It routes one of `NCH` W-bit channel streams, or the simulation stream, to the downstream bus. Channel choice can be manual or automatic MTI/NV per range cell. Configuration changes are applied only at sweep start, followed by a programmable blanking window, so no sweep ever carries mixed-source data.

## Interface
Parameters:
- `W`, 4, data width of each channel and of the output
- `NCH`, 3, number of channel inputs (≥2)
- `SELW`, 2, channel-select width (≥ clog2(NCH))
- `MTI_CH`, 2, channel index used when auto mode selects MTI
- `BLANK_CYC`, 8, output blanking length in cycles after a configuration change (0..255)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `trig`  in  1  sweep-start pulse, one cycle wide
- `mode_ch`  in  SELW  requested manual channel
- `mode_auto`  in  1  requested auto MTI/NV enable
- `data_source`  in  1  requested source: 1 = simulate, 0 = channels
- `auto`  in  1  per-cell auto decision: 1 = MTI
- `bits_in`  in  NCH*W  channel data; channel k occupies bits [k*W +: W]
- `simulate`  in  W  simulation data
- `in_valid`  in  1  qualifies `bits_in`, `simulate` and `auto`
- `bits`  out  W  selected data
- `bits_valid`  out  1  qualifies `bits`
- `mti_nv`  out  1  effective MTI selection for the current output cell
- `act_ch`  out  SELW  active manual channel
- `blanking`  out  1  high while the output is blanked

## Operation
- Active configuration registers: `act_ch`, `act_auto`, `act_src`. They are loaded from `mode_ch`, `mode_auto` and `data_source` only in a cycle where `trig`=1. Request inputs are ignored at all other times.
- `mode_ch` ≥ NCH sampled at `trig`: loaded as 0.
- At `trig`, if the sampled request differs from the active configuration (after the clamp), load it and enter BLANK. If it is identical, nothing changes and no blanking occurs.
- Two states:
  - RUN: normal selection.
  - BLANK: counter loaded with BLANK_CYC, decrements each cycle, returns to RUN when it expires. With BLANK_CYC = 0, BLANK is never entered.
- `trig` with a differing request during BLANK: reload the configuration and restart the counter at BLANK_CYC. `trig` with an identical request during BLANK: the count continues undisturbed.
- Channel selection in RUN, using the active configuration:
  - `act_src`=1: output `simulate`.
  - Otherwise, `act_auto`=1 and `auto`=1: output channel MTI_CH.
  - Otherwise: output channel `act_ch`.
- `mti_nv` = `act_auto` ? `auto` : (`act_ch` == MTI_CH). It is registered alongside `bits` and is valid regardless of `act_src`.
- In BLANK: `bits`=0, `bits_valid`=0, `mti_nv`=0, `blanking`=1.
- In RUN: `bits_valid` = `in_valid` delayed one cycle. When `in_valid`=0, `bits` holds its previous value.
- Reset state (asynchronous, while `rst_n`=0): state RUN, counter 0, `act_ch`=0, `act_auto`=0, `act_src`=0, `bits`=0, `bits_valid`=0, `mti_nv`=0, `blanking`=0.
- Reset mid-blank aborts the blank immediately. After reset the block runs with the reset configuration until the next `trig`.

## Timing
- Data latency: 1 cycle. Input at cycle n appears on `bits`, `bits_valid` and `mti_nv` at cycle n+1.
- `trig` with a changed configuration at cycle t:
  - `act_ch` shows the new value at t+1.
  - `blanking`=1 and `bits_valid`=0 for cycles t+1 .. t+BLANK_CYC.
  - Cycle t+BLANK_CYC+1 carries input from cycle t+BLANK_CYC, selected with the new configuration.
- With BLANK_CYC = 0: output at t+1 uses the old configuration; output at t+2 uses the new one.
- `auto` is sampled per cycle with its data. Switching in auto mode is cell-by-cell and never blanks.
- `trig` held high for several cycles is treated as a `trig` on each cycle. Each cycle with a differing request restarts the blank.

## Test plan
- Reset released, `in_valid`=1, channel 0 = 4'h3: `bits`=3 one cycle later. `act_ch`=0, `mti_nv`=0, `blanking`=0.
- `mode_ch`=1 held with no `trig`: output stays channel 0. Pulse `trig` at t with channel 1 = 4'hA: `blanking`=1 for cycles t+1..t+8, then `bits`=A with `bits_valid`=1 at t+9.
- Auto mode active with MTI_CH=2, channel 2 = 4'h5, `act_ch`=0, channel 0 = 4'h1; `auto` toggling 1,0,1: `bits` = 5,1,5 and `mti_nv` = 1,0,1, one cycle delayed, never blanked.
- `data_source`=1 at `trig`: after the blank, `bits` follows `simulate` (ramp 0..F) regardless of `auto`. A second `trig` issued 3 cycles into the blank with a new `mode_ch`: `blanking` extends to exactly 8 cycles after the second `trig`.
- `trig` with `mode_ch`=3 (NCH=3): `act_ch`=0, and a blank occurs only if the prior `act_ch` ≠ 0. `trig` with an identical configuration: `blanking` stays 0 and data continues uninterrupted.
- `rst_n` asserted at blank cycle 4: all outputs go 0 asynchronously. After release, the configuration is channel 0 manual and no blanking occurs.
